// File: rtl/lcd_line_scheduler_if.sv
// Requester-side bundle of the LCD line scheduler: line requests, grant,
// character fetch address/data and frame status.
interface lcd_line_scheduler_if #(
   parameter int LINES = 4,
   parameter int CHARS = 20
);
   localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;

   logic [LINES-1:0] req;
   logic [LINES-1:0] grant;
   logic [LW-1:0]    char_line;
   logic [CW-1:0]    char_idx;
   logic [7:0]       char_data;
   logic             busy;
   logic             frame_done;

   modport master (
      input  req, char_data,
      output grant, char_line, char_idx, busy, frame_done
   );

   modport slave (
      output req, char_data,
      input  grant, char_line, char_idx, busy, frame_done
   );
endinterface

// File: rtl/lcd_line_scheduler.sv
// Round-robin owner of the LCD character bus, one full line per grant.
// Define LCD_BUSY_POLL_EN to replace the fixed write hold with busy-flag reads.
module lcd_line_scheduler #(
   parameter int         LINES = 4,
   parameter int         CHARS = 20,
   parameter logic [6:0] LINE_STARTS [LINES] = '{7'h00, 7'h40, 7'h14, 7'h54},
   parameter int         E_SETUP = 2,
   parameter int         E_HIGH = 12,
   parameter int         WR_WAIT = 2500
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 initialized,
   lcd_line_scheduler_if.master bus,
   output logic                 lcd_rs,
   output logic                 lcd_rw,
   output logic                 lcd_e,
   output logic [7:0]           lcd_data_out,
`ifdef LCD_BUSY_POLL_EN
   input  logic [7:0]           lcd_data_in,
`endif
   output logic                 lcd_data_oe
);
   localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;
   localparam int TMAX = (E_SETUP > E_HIGH) ?
      ((E_SETUP > WR_WAIT) ? E_SETUP : WR_WAIT) :
      ((E_HIGH > WR_WAIT) ? E_HIGH : WR_WAIT);
   localparam int TW = $clog2(TMAX + 1);

   localparam logic [TW-1:0] T_SETUP = TW'(E_SETUP - 1);
   localparam logic [TW-1:0] T_HIGH = TW'(E_HIGH - 1);
   localparam logic [CW-1:0] LAST_CHAR = CW'(CHARS - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_PULSE = 3'd2;
   localparam logic [2:0] S_DONE = 3'd4;
`ifdef LCD_BUSY_POLL_EN
   localparam logic [2:0] S_RD_SETUP = 3'd5;
   localparam logic [2:0] S_RD_HIGH = 3'd6;
   localparam logic [2:0] S_RD_LOW = 3'd7;
`else
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [TW-1:0] T_WAIT = TW'(WR_WAIT - 1);
`endif

   logic [2:0]       state;
   logic [TW-1:0]    cnt;
   logic [LW-1:0]    ptr;
   logic [LINES-1:0] grant;
   logic [LW-1:0]    char_line;
   logic [CW-1:0]    char_idx;
   logic             busy;
   logic             frame_done;
   logic             data_phase;
   logic             adv;
   logic             last_write;

   logic [LW-1:0]    win;
   logic [LW-1:0]    ptr_nxt;
   logic             found;
   int               scan;

   assign bus.grant = grant;
   assign bus.char_line = char_line;
   assign bus.char_idx = char_idx;
   assign bus.busy = busy;
   assign bus.frame_done = frame_done;

   // First requester at or after the pointer, wrapping past LINES-1.
   always_comb begin
      win = ptr;
      found = 1'b0;
      scan = 0;
      for (int k = 0; k < LINES; k++) begin
         scan = int'(ptr) + k;
         if (scan >= LINES) scan = scan - LINES;
         if (!found && bus.req[LW'(scan)]) begin
            found = 1'b1;
            win = LW'(scan);
         end
      end
      ptr_nxt = (int'(win) == LINES - 1) ? '0 : win + 1'b1;
   end

   assign last_write = data_phase && (char_idx == LAST_CHAR);

`ifdef LCD_BUSY_POLL_EN
   logic rw_q;
   logic flag;
   assign lcd_rw = rw_q;
   assign adv = (state == S_RD_LOW) && (cnt == '0) && !flag;
`else
   assign lcd_rw = 1'b0;
   assign adv = (state == S_HOLD) && (cnt == '0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         ptr <= '0;
         grant <= '0;
         char_line <= '0;
         char_idx <= '0;
         busy <= 1'b0;
         frame_done <= 1'b0;
         data_phase <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_e <= 1'b0;
         lcd_data_out <= '0;
         lcd_data_oe <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
         rw_q <= 1'b0;
         flag <= 1'b0;
`endif
      end else if (state != S_IDLE && !initialized) begin
         // Initialiser went away: drop the bus now, no completion pulse.
         state <= S_IDLE;
         grant <= '0;
         busy <= 1'b0;
         lcd_e <= 1'b0;
         lcd_data_oe <= 1'b0;
         frame_done <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
         rw_q <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (initialized && found) begin
                  grant <= LINES'(1) << win;
                  char_line <= win;
                  char_idx <= '0;
                  busy <= 1'b1;
                  ptr <= ptr_nxt;
                  data_phase <= 1'b0;
                  lcd_rs <= 1'b0;
                  lcd_data_out <= {1'b1, LINE_STARTS[win]};
                  lcd_data_oe <= 1'b1;
                  cnt <= T_SETUP;
                  state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (data_phase && cnt == T_SETUP)
                  lcd_data_out <= bus.char_data;
               if (cnt == '0) begin
                  lcd_e <= 1'b1;
                  cnt <= T_HIGH;
                  state <= S_PULSE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_PULSE: begin
               if (cnt == '0) begin
                  lcd_e <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
                  lcd_rs <= 1'b0;
                  rw_q <= 1'b1;
                  lcd_data_oe <= 1'b0;
                  cnt <= T_SETUP;
                  state <= S_RD_SETUP;
`else
                  cnt <= T_WAIT;
                  state <= S_HOLD;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`ifdef LCD_BUSY_POLL_EN
            S_RD_SETUP: begin
               if (cnt == '0) begin
                  lcd_e <= 1'b1;
                  cnt <= T_HIGH;
                  state <= S_RD_HIGH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RD_HIGH: begin
               if (cnt == '0) begin
                  flag <= lcd_data_in[7];
                  lcd_e <= 1'b0;
                  cnt <= T_SETUP;
                  state <= S_RD_LOW;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RD_LOW: begin
               if (cnt == '0) begin
                  if (flag) begin
                     lcd_e <= 1'b1;
                     cnt <= T_HIGH;
                     state <= S_RD_HIGH;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`else
            S_HOLD: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
`endif
            S_DONE: begin
               frame_done <= 1'b1;
               grant <= '0;
               busy <= 1'b0;
               lcd_data_oe <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
               rw_q <= 1'b0;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // End of a write's wait: next character, or close the frame.
         if (adv) begin
            if (last_write) begin
               state <= S_DONE;
            end else begin
               state <= S_SETUP;
               cnt <= T_SETUP;
               data_phase <= 1'b1;
               lcd_rs <= 1'b1;
               char_idx <= data_phase ? char_idx + 1'b1 : '0;
`ifdef LCD_BUSY_POLL_EN
               rw_q <= 1'b0;
               lcd_data_oe <= 1'b1;
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Scoreboard bench for lcd_line_scheduler: stimulus queues expected grants and
// LCD writes, a negedge monitor checks every strobe, grant and frame end.
module tb_lcd_line_scheduler;
   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } wr_t;

   localparam logic [6:0] STARTS [4] = '{7'h00, 7'h40, 7'h14, 7'h54};

   logic       clk = 1'b0;
   logic       reset;
   logic       initialized;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic       lcd_data_oe;
   logic [7:0] lcd_data_out;

   lcd_line_scheduler_if #(.LINES(4), .CHARS(20)) bus ();

   lcd_line_scheduler #(
      .LINES(4), .CHARS(20),
      .E_SETUP(2), .E_HIGH(3), .WR_WAIT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .initialized(initialized),
      .bus(bus),
      .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw),
      .lcd_e(lcd_e),
      .lcd_data_out(lcd_data_out),
      .lcd_data_oe(lcd_data_oe)
   );

   always #5 clk = ~clk;

   // Requester model: each character encodes its own line and index.
   assign bus.char_data = {1'b1, bus.char_line, bus.char_idx};

   wr_t        exp_wr[$];
   logic [3:0] exp_grant[$];
   int         done_exp = 0;
   bit         chk_gap = 1'b0;
   bit         final_req = 1'b0;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         grant_cyc = 0;
   int         done_cyc = 0;
   int         e_w = 0;
   int         done_seen = 0;
   bit         rst_q = 1'b0;
   bit         init_q = 1'b0;
   bit         e_q = 1'b0;
   bit         have_done = 1'b0;
   bit         final_ack = 1'b0;
   logic [3:0] grant_q = '0;

   task automatic chk(input string name, input logic [39:0] got,
                      input logic [39:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, got, req);
      end
   endtask

   always @(posedge clk) begin
      rst_q = reset;
      init_q = initialized;
   end

   always @(negedge clk) begin
      wr_t        w;
      logic [3:0] g;
      cyc++;
      if (rst_q) begin
         chk("reset_state",
             40'({bus.grant, bus.char_line, bus.char_idx, bus.busy,
                  bus.frame_done, lcd_rs, lcd_rw, lcd_e, lcd_data_out,
                  lcd_data_oe}), 40'(0));
         have_done = 1'b0;
         e_w = 0;
      end else begin
         if (!init_q)
            chk("init_gate", 40'({bus.grant, bus.busy, lcd_e}), 40'(0));
         if (lcd_e && !e_q) begin
            chk("write_queued", 40'(exp_wr.size() != 0), 40'(1));
            if (exp_wr.size() != 0) begin
               w = exp_wr.pop_front();
               chk("lcd_write",
                   40'({lcd_rs, lcd_rw, lcd_data_oe, lcd_data_out}),
                   40'({w.rs, 1'b0, 1'b1, w.data}));
            end
         end
         if (lcd_e) e_w++;
         if (!lcd_e && e_q) begin
            if (init_q) chk("e_width", 40'(e_w), 40'(3));
            e_w = 0;
         end
         if (bus.grant != 4'b0 && grant_q == 4'b0) begin
            chk("grant_queued", 40'(exp_grant.size() != 0), 40'(1));
            if (exp_grant.size() != 0) begin
               g = exp_grant.pop_front();
               chk("grant", 40'(bus.grant), 40'(g));
            end
            if (chk_gap && have_done)
               chk("frame_gap", 40'(cyc - done_cyc), 40'(1));
            grant_cyc = cyc;
         end
         if (bus.frame_done) begin
            done_seen++;
            chk("frame_len", 40'(cyc - grant_cyc), 40'(190));
            chk("done_expected", 40'(done_seen <= done_exp), 40'(1));
            chk("done_release", 40'({bus.grant, bus.busy, lcd_data_oe}), 40'(0));
            have_done = 1'b1;
            done_cyc = cyc;
         end
         if (final_req && !final_ack) begin
            chk("writes_left", 40'(exp_wr.size()), 40'(0));
            chk("grants_left", 40'(exp_grant.size()), 40'(0));
            chk("done_count", 40'(done_seen), 40'(done_exp));
            final_ack = 1'b1;
         end
      end
      e_q = rst_q ? 1'b0 : lcd_e;
      grant_q = rst_q ? 4'b0 : bus.grant;
   end

   function automatic bit cond(input int sel);
      case (sel)
         0: return bus.frame_done;
         1: return bus.grant != 4'b0;
         2: return lcd_e && lcd_rs && bus.char_idx == 5'd7;
         3: return lcd_e && lcd_rs && bus.char_idx == 5'd12;
         default: return !lcd_e;
      endcase
   endfunction

   task automatic wait_until(input int sel, input int limit, input string what);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cond(sel) && n < limit);
      if (!cond(sel)) begin
         $display("FAIL timeout %s: no event after %0d cycles, required one", what, limit);
         $fatal(1, "bench stopped on timeout");
      end
   endtask

   task automatic push_frame(input int line, input int nchars);
      wr_t w;
      w.rs = 1'b0;
      w.data = {1'b1, STARTS[line]};
      exp_wr.push_back(w);
      for (int k = 0; k < nchars; k++) begin
         w.rs = 1'b1;
         w.data = {1'b1, 2'(line), 5'(k)};
         exp_wr.push_back(w);
      end
   endtask

   initial begin
      reset = 1'b1;
      initialized = 1'b0;
      bus.req = 4'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      bus.req = 4'b1111;
      repeat (100) @(negedge clk);

      exp_grant.push_back(4'b0010);
      push_frame(1, 20);
      done_exp++;
      bus.req = 4'b0010;
      initialized = 1'b1;
      wait_until(1, 10, "single grant");
      bus.req = 4'b0;
      wait_until(0, 400, "single frame_done");

      exp_grant.push_back(4'b1000);
      push_frame(3, 8);
      bus.req = 4'b1000;
      wait_until(2, 400, "char 7 pulse");
      initialized = 1'b0;
      repeat (5) @(negedge clk);
      exp_grant.push_back(4'b1000);
      push_frame(3, 20);
      done_exp++;
      initialized = 1'b1;
      wait_until(1, 10, "restart grant");
      bus.req = 4'b0;
      wait_until(0, 400, "restart frame_done");

      exp_grant.push_back(4'b0001);
      push_frame(0, 13);
      bus.req = 4'b0001;
      wait_until(3, 400, "char 12 pulse");
      wait_until(4, 10, "char 12 hold");
      reset = 1'b1;
      bus.req = 4'b0;
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         exp_grant.push_back(4'b0001 << (i % 4));
         push_frame(i % 4, 20);
      end
      done_exp += 5;
      chk_gap = 1'b1;
      bus.req = 4'b1111;
      repeat (4) wait_until(0, 400, "rr frame_done");
      wait_until(1, 10, "rr fifth grant");
      bus.req = 4'b0;
      wait_until(0, 400, "rr last frame_done");

      final_req = 1'b1;
      for (int n = 0; n < 10 && !final_ack; n++) @(negedge clk);
      if (!final_ack) begin
         $display("FAIL timeout final_check: no ack after 10 cycles, required one");
         $fatal(1, "bench stopped on timeout");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
